// File: rtl/vh_parity_pkg.sv
// vh_parity_pkg: codeword geometry helpers shared by the 2-D parity encoder and its calculator.
package vh_parity_pkg;

  function automatic int cw_width(input int rows, input int cols, input int corner);
    return rows * cols + rows + cols + corner;
  endfunction

  // Parity bits sit above the data: row parities first, then column parities, then the corner bit.
  function automatic int row_base(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int col_base(input int rows, input int cols);
    return rows * cols + rows;
  endfunction

endpackage

// File: rtl/vh_parity_calc.sv
// vh_parity_calc: combinational row/column/corner parity of a ROWS x COLS grid.
module vh_parity_calc
  import vh_parity_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CORNER = 0
) (
  input  logic [ROWS*COLS-1:0]        data,
  input  logic                        odd,
  output logic [ROWS+COLS+CORNER-1:0] par
);

  localparam int COL_OFF = col_base(ROWS, COLS) - row_base(ROWS, COLS);

  genvar r, c;

  for (r = 0; r < ROWS; r++) begin : g_row
    assign par[r] = ^data[r*COLS +: COLS] ^ odd;
  end

  for (c = 0; c < COLS; c++) begin : g_col
    logic [ROWS-1:0] cells;
    for (r = 0; r < ROWS; r++) begin : g_cell
      assign cells[r] = data[r*COLS+c];
    end
    assign par[COL_OFF+c] = ^cells ^ odd;
  end

  if (CORNER != 0) begin : g_corner
    assign par[ROWS+COLS] = ^data ^ odd;
  end

endmodule

// File: rtl/vh_parity_encoder.sv
// vh_parity_encoder: two-stage valid/ready 2-D parity encoder with delivered-codeword counter.
module vh_parity_encoder
  import vh_parity_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CORNER = 0,
  parameter int CNT_W  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ROWS*COLS-1:0]                  in_data,
  input  logic                                  in_odd,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [ROWS*COLS+ROWS+COLS+CORNER-1:0] out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CNT_W-1:0]                      out_count
);

  localparam int N  = ROWS * COLS;
  localparam int W  = cw_width(ROWS, COLS, CORNER);
  localparam int PW = W - N;

  logic          s1_valid_q, s1_valid_d;
  logic [N-1:0]  s1_data_q, s1_data_d;
  logic          s1_odd_q, s1_odd_d;
  logic          s2_valid_q, s2_valid_d;
  logic [W-1:0]  s2_data_q, s2_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0] par;
  logic          in_fire, out_fire, s2_adv;

  vh_parity_calc #(.ROWS(ROWS), .COLS(COLS), .CORNER(CORNER)) u_calc (
    .data (s1_data_q),
    .odd  (s1_odd_q),
    .par  (par)
  );

  // in_ready looks through to out_ready so a full pipe still streams one word per cycle.
  always_comb begin
    out_fire   = s2_valid_q && out_ready;
    s2_adv     = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready   = !s1_valid_q || s2_adv;
    in_fire    = in_valid && in_ready;
    s1_valid_d = in_fire || (s1_valid_q && !s2_adv);
    s1_data_d  = in_fire ? in_data : s1_data_q;
    s1_odd_d   = in_fire ? in_odd : s1_odd_q;
    s2_valid_d = s2_adv || (s2_valid_q && !out_ready);
    s2_data_d  = s2_adv ? {par, s1_data_q} : s2_data_q;
    cnt_d      = cnt_q + CNT_W'(out_fire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_odd_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_odd_q   <= s1_odd_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_data  = s2_data_q;
  assign out_valid = s2_valid_q;
  assign out_count = cnt_q;

endmodule
